// File: rtl/ula_muldiv_ctrl.sv
// EX-stage ALU control decode plus iterative multiply/divide engine with HI/LO.
// Multiply/divide complete WIDTH+1 cycles after accept; MTHI/MTLO and divide-by-zero finish without asserting busy.
module ula_muldiv_ctrl #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [1:0]       ALUOp,
    input  logic [5:0]       func,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic [3:0]       OP,
    output logic             busy,
    output logic             done,
    output logic             div_by_zero,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);

    localparam int CNT_W = $clog2(WIDTH) + 1;
    localparam logic [CNT_W-1:0] LAST = CNT_W'(WIDTH - 1);

    localparam logic [5:0] F_MULT  = 6'b011000;
    localparam logic [5:0] F_MULTU = 6'b011001;
    localparam logic [5:0] F_DIV   = 6'b011010;
    localparam logic [5:0] F_DIVU  = 6'b011011;
    localparam logic [5:0] F_MTHI  = 6'b010001;
    localparam logic [5:0] F_MTLO  = 6'b010011;

    typedef enum logic [1:0] {IDLE, RUN, FIX} state_t;

    state_t             state_q;
    logic [CNT_W-1:0]   cnt_q;
    logic               busy_q, done_q, dbz_q;
    logic               mul_q, neg_q, rneg_q, dz_q;
    logic [WIDTH-1:0]   hi_q, lo_q;
    logic [WIDTH-1:0]   opnd_q, acc_hi_q, acc_lo_q;

    always_comb begin
        OP = 4'b0000;
        case (ALUOp)
            2'b00: OP = 4'b0010;
            2'b01: OP = 4'b0110;
            2'b11: OP = 4'b1111;
            default: begin
                case (func)
                    6'b100000: OP = 4'b0001;
                    6'b100010: OP = 4'b0010;
                    6'b100100: OP = 4'b0011;
                    6'b100101: OP = 4'b0100;
                    6'b100110: OP = 4'b0101;
                    6'b100111: OP = 4'b0110;
                    6'b000000: OP = 4'b0111;
                    6'b000010: OP = 4'b1000;
                    6'b000011: OP = 4'b1001;
                    6'b101010: OP = 4'b1010;
                    6'b101011: OP = 4'b1011;
                    F_MULT, F_MULTU: OP = 4'b1100;
                    F_DIV, F_DIVU:   OP = 4'b1101;
                    6'b100001: OP = 4'b1110;
                    6'b100011: OP = 4'b1111;
                    default:   OP = 4'b0000;
                endcase
            end
        endcase
    end

    logic is_r, is_mul, is_div, is_sgn, is_mthi, is_mtlo, accept;
    logic a_neg, b_neg;
    logic [WIDTH-1:0] a_abs, b_abs;

    assign is_r    = (ALUOp == 2'b10);
    assign is_mul  = is_r && (func == F_MULT || func == F_MULTU);
    assign is_div  = is_r && (func == F_DIV  || func == F_DIVU);
    assign is_mthi = is_r && (func == F_MTHI);
    assign is_mtlo = is_r && (func == F_MTLO);
    assign is_sgn  = (func == F_MULT) || (func == F_DIV);
    assign accept  = start && (state_q == IDLE) && (is_mul || is_div || is_mthi || is_mtlo);

    assign a_neg = is_sgn && a[WIDTH-1];
    assign b_neg = is_sgn && b[WIDTH-1];
    assign a_abs = a_neg ? -a : a;
    assign b_abs = b_neg ? -b : b;

    // One iteration: shift-add on {acc_hi,acc_lo} for multiply, restoring step for divide.
    logic [WIDTH:0]     mul_sum, div_shift, div_diff;
    logic               div_ge;
    logic [WIDTH-1:0]   step_hi, step_lo;
    logic [2*WIDTH-1:0] prod_fix;
    logic [WIDTH-1:0]   quo_fix, rem_fix;

    assign mul_sum   = {1'b0, acc_hi_q} + (acc_lo_q[0] ? {1'b0, opnd_q} : '0);
    assign div_shift = {acc_hi_q, acc_lo_q[WIDTH-1]};
    assign div_diff  = div_shift - {1'b0, opnd_q};
    assign div_ge    = ~div_diff[WIDTH];
    assign step_hi   = mul_q ? mul_sum[WIDTH:1]
                             : (div_ge ? div_diff[WIDTH-1:0] : div_shift[WIDTH-1:0]);
    assign step_lo   = mul_q ? {mul_sum[0], acc_lo_q[WIDTH-1:1]}
                             : {acc_lo_q[WIDTH-2:0], div_ge};
    assign prod_fix  = neg_q ? -{acc_hi_q, acc_lo_q} : {acc_hi_q, acc_lo_q};
    assign quo_fix   = neg_q  ? -acc_lo_q : acc_lo_q;
    assign rem_fix   = rneg_q ? -acc_hi_q : acc_hi_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            dbz_q    <= 1'b0;
            mul_q    <= 1'b0;
            neg_q    <= 1'b0;
            rneg_q   <= 1'b0;
            dz_q     <= 1'b0;
            hi_q     <= '0;
            lo_q     <= '0;
            opnd_q   <= '0;
            acc_hi_q <= '0;
            acc_lo_q <= '0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (accept) begin
                        dbz_q <= 1'b0;
                        if (is_mthi) begin
                            hi_q   <= a;
                            done_q <= 1'b1;
                        end else if (is_mtlo) begin
                            lo_q   <= a;
                            done_q <= 1'b1;
                        end else if (is_div && b == '0) begin
                            // Divide by zero takes the FIX slot without raising busy.
                            state_q <= FIX;
                            dz_q    <= 1'b1;
                            opnd_q  <= a;
                        end else begin
                            state_q  <= RUN;
                            busy_q   <= 1'b1;
                            cnt_q    <= '0;
                            dz_q     <= 1'b0;
                            mul_q    <= is_mul;
                            neg_q    <= a_neg ^ b_neg;
                            rneg_q   <= a_neg;
                            opnd_q   <= is_mul ? a_abs : b_abs;
                            acc_hi_q <= '0;
                            acc_lo_q <= is_mul ? b_abs : a_abs;
                        end
                    end
                end
                RUN: begin
                    acc_hi_q <= step_hi;
                    acc_lo_q <= step_lo;
                    cnt_q    <= cnt_q + 1'b1;
                    if (cnt_q == LAST) state_q <= FIX;
                end
                FIX: begin
                    state_q <= IDLE;
                    busy_q  <= 1'b0;
                    done_q  <= 1'b1;
                    if (dz_q) begin
                        hi_q  <= opnd_q;
                        lo_q  <= '1;
                        dbz_q <= 1'b1;
                    end else if (mul_q) begin
                        {hi_q, lo_q} <= prod_fix;
                    end else begin
                        hi_q <= rem_fix;
                        lo_q <= quo_fix;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign busy        = busy_q;
    assign done        = done_q;
    assign div_by_zero = dbz_q;
    assign hi          = hi_q;
    assign lo          = lo_q;

endmodule

// File: tb/tb_ula_muldiv_ctrl.sv
// Directed bench for ula_muldiv_ctrl at WIDTH=32: decode table, mul/div results, timing, div-by-zero, reset.
module tb_ula_muldiv_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic [1:0]  ALUOp;
    logic [5:0]  func;
    logic        start;
    logic [31:0] a, b;
    logic [3:0]  OP;
    logic        busy, done, div_by_zero;
    logic [31:0] hi, lo;

    int cmp_cnt = 0;
    int err_cnt = 0;

    ula_muldiv_ctrl #(.WIDTH(32)) dut (
        .clk(clk), .rst(rst), .ALUOp(ALUOp), .func(func), .start(start),
        .a(a), .b(b), .OP(OP), .busy(busy), .done(done),
        .div_by_zero(div_by_zero), .hi(hi), .lo(lo)
    );

    always #5 clk = ~clk;

    // Drive one start pulse; returns at the negedge ending the cycle after the accept edge.
    task automatic issue(input logic [5:0] f, input logic [31:0] av, input logic [31:0] bv);
        @(negedge clk);
        ALUOp = 2'b10; func = f; a = av; b = bv; start = 1'b1;
        @(negedge clk);
        start = 1'b0; func = 6'b100000; a = 32'hDEAD_BEEF; b = 32'h0;
    endtask

    task automatic measure(output int busy_n, output int done_n, output int done_k,
                           output logic [31:0] mid_hi);
        busy_n = 0; done_n = 0; done_k = 0; mid_hi = '0;
        for (int k = 1; k <= 45; k++) begin
            if (busy) busy_n++;
            if (done) begin
                done_n++;
                if (done_k == 0) done_k = k;
            end
            if (k == 5) mid_hi = hi;
            @(negedge clk);
        end
    endtask

    task automatic test_reset;
        rst = 1'b1; start = 1'b0; ALUOp = 2'b00; func = '0; a = '0; b = '0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        cmp_cnt++; if (hi !== 32'h0) begin err_cnt++; $display("FAIL reset_hi got %h want 0", hi); end
        cmp_cnt++; if (lo !== 32'h0) begin err_cnt++; $display("FAIL reset_lo got %h want 0", lo); end
        cmp_cnt++; if (busy !== 1'b0) begin err_cnt++; $display("FAIL reset_busy got %b want 0", busy); end
        cmp_cnt++; if (done !== 1'b0) begin err_cnt++; $display("FAIL reset_done got %b want 0", done); end
        cmp_cnt++; if (div_by_zero !== 1'b0) begin err_cnt++; $display("FAIL reset_dbz got %b want 0", div_by_zero); end
    endtask

    task automatic test_op_decode;
        logic [11:0] vec [0:22] = '{
            {2'b00, 6'b000000, 4'b0010}, {2'b01, 6'b100000, 4'b0110}, {2'b11, 6'b000000, 4'b1111},
            {2'b10, 6'b100000, 4'b0001}, {2'b10, 6'b100010, 4'b0010}, {2'b10, 6'b100100, 4'b0011},
            {2'b10, 6'b100101, 4'b0100}, {2'b10, 6'b100110, 4'b0101}, {2'b10, 6'b100111, 4'b0110},
            {2'b10, 6'b000000, 4'b0111}, {2'b10, 6'b000010, 4'b1000}, {2'b10, 6'b000011, 4'b1001},
            {2'b10, 6'b101010, 4'b1010}, {2'b10, 6'b101011, 4'b1011}, {2'b10, 6'b011000, 4'b1100},
            {2'b10, 6'b011001, 4'b1100}, {2'b10, 6'b011010, 4'b1101}, {2'b10, 6'b011011, 4'b1101},
            {2'b10, 6'b100001, 4'b1110}, {2'b10, 6'b100011, 4'b1111}, {2'b10, 6'b111111, 4'b0000},
            {2'b10, 6'b010001, 4'b0000}, {2'b10, 6'b010011, 4'b0000}
        };
        logic [11:0] v;
        start = 1'b0;
        for (int i = 0; i < 23; i++) begin
            v = vec[i];
            ALUOp = v[11:10]; func = v[9:4];
            #1;
            cmp_cnt++;
            if (OP !== v[3:0]) begin
                err_cnt++;
                $display("FAIL op_decode aluop=%b func=%b got %b want %b", v[11:10], v[9:4], OP, v[3:0]);
            end
        end
    endtask

    task automatic test_mult;
        int bn, dn, dk; logic [31:0] mh;
        issue(6'b011000, 32'd7, 32'hFFFF_FFFD);
        measure(bn, dn, dk, mh);
        cmp_cnt++; if (bn != 33) begin err_cnt++; $display("FAIL mult_busy_cycles got %0d want 33", bn); end
        cmp_cnt++; if (dk != 34) begin err_cnt++; $display("FAIL mult_done_cycle got %0d want 34", dk); end
        cmp_cnt++; if (dn != 1) begin err_cnt++; $display("FAIL mult_done_count got %0d want 1", dn); end
        cmp_cnt++; if (mh !== 32'h0) begin err_cnt++; $display("FAIL mult_hi_hold got %h want 0", mh); end
        cmp_cnt++; if (hi !== 32'hFFFF_FFFF) begin err_cnt++; $display("FAIL mult_hi got %h want ffffffff", hi); end
        cmp_cnt++; if (lo !== 32'hFFFF_FFEB) begin err_cnt++; $display("FAIL mult_lo got %h want ffffffeb", lo); end
    endtask

    task automatic test_multu_divu;
        int bn, dn, dk; logic [31:0] mh;
        issue(6'b011001, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
        measure(bn, dn, dk, mh);
        cmp_cnt++; if (hi !== 32'hFFFF_FFFE) begin err_cnt++; $display("FAIL multu_hi got %h want fffffffe", hi); end
        cmp_cnt++; if (lo !== 32'h0000_0001) begin err_cnt++; $display("FAIL multu_lo got %h want 00000001", lo); end
        issue(6'b011011, 32'd100, 32'd7);
        measure(bn, dn, dk, mh);
        cmp_cnt++; if (mh !== 32'hFFFF_FFFE) begin err_cnt++; $display("FAIL divu_hi_hold got %h want fffffffe", mh); end
        cmp_cnt++; if (dk != 34) begin err_cnt++; $display("FAIL divu_done_cycle got %0d want 34", dk); end
        cmp_cnt++; if (lo !== 32'd14) begin err_cnt++; $display("FAIL divu_lo got %h want 0000000e", lo); end
        cmp_cnt++; if (hi !== 32'd2) begin err_cnt++; $display("FAIL divu_hi got %h want 00000002", hi); end
    endtask

    task automatic test_div_signed;
        int bn, dn, dk; logic [31:0] mh;
        issue(6'b011010, 32'hFFFF_FFF9, 32'd2);
        measure(bn, dn, dk, mh);
        cmp_cnt++; if (lo !== 32'hFFFF_FFFD) begin err_cnt++; $display("FAIL div_neg_lo got %h want fffffffd", lo); end
        cmp_cnt++; if (hi !== 32'hFFFF_FFFF) begin err_cnt++; $display("FAIL div_neg_hi got %h want ffffffff", hi); end
        issue(6'b011010, 32'h8000_0000, 32'hFFFF_FFFF);
        measure(bn, dn, dk, mh);
        cmp_cnt++; if (lo !== 32'h8000_0000) begin err_cnt++; $display("FAIL div_minint_lo got %h want 80000000", lo); end
        cmp_cnt++; if (hi !== 32'h0) begin err_cnt++; $display("FAIL div_minint_hi got %h want 0", hi); end
        cmp_cnt++; if (div_by_zero !== 1'b0) begin err_cnt++; $display("FAIL div_minint_dbz got %b want 0", div_by_zero); end
    endtask

    task automatic test_div_zero;
        int bn, dn, dk; logic [31:0] mh;
        issue(6'b011010, 32'd5, 32'd0);
        measure(bn, dn, dk, mh);
        cmp_cnt++; if (bn != 0) begin err_cnt++; $display("FAIL dz_busy_cycles got %0d want 0", bn); end
        cmp_cnt++; if (dk != 2) begin err_cnt++; $display("FAIL dz_done_cycle got %0d want 2", dk); end
        cmp_cnt++; if (dn != 1) begin err_cnt++; $display("FAIL dz_done_count got %0d want 1", dn); end
        cmp_cnt++; if (div_by_zero !== 1'b1) begin err_cnt++; $display("FAIL dz_flag got %b want 1", div_by_zero); end
        cmp_cnt++; if (hi !== 32'd5) begin err_cnt++; $display("FAIL dz_hi got %h want 00000005", hi); end
        cmp_cnt++; if (lo !== 32'hFFFF_FFFF) begin err_cnt++; $display("FAIL dz_lo got %h want ffffffff", lo); end
        issue(6'b011000, 32'd2, 32'd3);
        cmp_cnt++; if (div_by_zero !== 1'b0) begin err_cnt++; $display("FAIL dz_clear got %b want 0", div_by_zero); end
        measure(bn, dn, dk, mh);
        cmp_cnt++; if (lo !== 32'd6) begin err_cnt++; $display("FAIL dz_next_mult_lo got %h want 00000006", lo); end
    endtask

    task automatic test_back_to_back;
        int dn; int dk;
        dn = 0; dk = 0;
        issue(6'b011000, 32'd3, 32'd5);
        for (int k = 1; k <= 45 && dk == 0; k++) begin
            if (done) begin dn++; dk = k; end
            if (k == 5) begin
                ALUOp = 2'b10; func = 6'b011010; a = 32'd100; b = 32'd7; start = 1'b1;
            end else if (dk != 0) begin
                // Next op requested in the same cycle done is high.
                ALUOp = 2'b10; func = 6'b010011; a = 32'h0000_ABCD; start = 1'b1;
            end else begin
                start = 1'b0;
            end
            @(negedge clk);
        end
        start = 1'b0;
        cmp_cnt++; if (dk != 34) begin err_cnt++; $display("FAIL b2b_done_cycle got %0d want 34", dk); end
        cmp_cnt++; if (lo !== 32'h0000_ABCD) begin err_cnt++; $display("FAIL b2b_mtlo_lo got %h want 0000abcd", lo); end
        cmp_cnt++; if (hi !== 32'h0) begin err_cnt++; $display("FAIL b2b_mult_hi got %h want 0", hi); end
        cmp_cnt++; if (done !== 1'b1) begin err_cnt++; $display("FAIL b2b_mtlo_done got %b want 1", done); end
        for (int k = 0; k < 40; k++) begin
            if (done) dn++;
            @(negedge clk);
        end
        cmp_cnt++; if (dn != 2) begin err_cnt++; $display("FAIL b2b_done_count got %0d want 2", dn); end
        issue(6'b010001, 32'h0000_1234, 32'h0);
        cmp_cnt++; if (hi !== 32'h0000_1234) begin err_cnt++; $display("FAIL mthi_hi got %h want 00001234", hi); end
        cmp_cnt++; if (lo !== 32'h0000_ABCD) begin err_cnt++; $display("FAIL mthi_lo got %h want 0000abcd", lo); end
        cmp_cnt++; if (busy !== 1'b0 || done !== 1'b1) begin
            err_cnt++; $display("FAIL mthi_flags got busy=%b done=%b want busy=0 done=1", busy, done);
        end
    endtask

    task automatic test_rst_mid;
        int dn;
        dn = 0;
        issue(6'b011011, 32'd1000, 32'd3);
        for (int k = 1; k < 10; k++) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        cmp_cnt++; if (busy !== 1'b0) begin err_cnt++; $display("FAIL rst_mid_busy got %b want 0", busy); end
        for (int k = 0; k < 45; k++) begin
            if (done || busy) dn++;
            @(negedge clk);
        end
        cmp_cnt++; if (dn != 0) begin err_cnt++; $display("FAIL rst_mid_activity got %0d want 0", dn); end
        cmp_cnt++; if (hi !== 32'h0) begin err_cnt++; $display("FAIL rst_mid_hi got %h want 0", hi); end
        cmp_cnt++; if (lo !== 32'h0) begin err_cnt++; $display("FAIL rst_mid_lo got %h want 0", lo); end
    endtask

    initial begin
        test_reset;
        test_op_decode;
        test_mult;
        test_multu_divu;
        test_div_signed;
        test_div_zero;
        test_back_to_back;
        test_rst_mid;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp_cnt, err_cnt);
        $finish;
    end

endmodule
